// File: rtl/sat_arith_left_shift_seq.sv
// -----------------------------------------------------------------------------
// sat_arith_left_shift_seq
//
// Sequential signed multiply-by-2^s with saturation. Accepts a signed N-bit
// operand and an unsigned shift amount. It then shifts the operand left one bit
// per cycle. Before each step it checks whether the shift would flip the sign.
// If it would, the operation stops early and the result is clamped to the most
// positive or the most negative value, with out_ovf set.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand present
//   in_ready   block can accept an operand (IDLE and not in reset)
//   in_data    signed operand a, N bits, two's complement
//   in_shift   unsigned shift amount s, SW bits
//   out_valid  result present
//   out_ready  consumer accepts the result
//   out_data   saturate(a * 2**s), held stable while out_valid
//   out_ovf    1 if saturation occurred; qualified by out_valid
// -----------------------------------------------------------------------------
module sat_arith_left_shift_seq #(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          accept;

  // Clamp value selected by the sign of the original operand.
  function automatic logic [N-1:0] sat_value(input logic neg);
    logic [N-1:0] v;
    if (neg) begin
      v = {1'b1, {(N-1){1'b0}}};
    end else begin
      v = {1'b0, {(N-1){1'b1}}};
    end
    return v;
  endfunction

  // Readiness is forced low while reset is held, even before the first edge.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d     = in_data;
          cnt_d     = in_shift;
          sign_d    = in_data[N-1];
          out_ovf_d = 1'b0;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == {SW{1'b0}}) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (acc_q[N-1] != acc_q[N-2]) begin
          // The next shift would change the sign, so saturate now.
          out_ovf_d   = 1'b1;
          out_data_d  = sat_value(sign_q);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          acc_d   = {acc_q[N-2:0], 1'b0};
          cnt_d   = cnt_q - {{(SW-1){1'b0}}, 1'b1};
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {N{1'b0}};
      cnt_q       <= {SW{1'b0}};
      sign_q      <= 1'b0;
      out_data_q  <= {N{1'b0}};
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sat_arith_left_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_sat_arith_left_shift_seq
//
// Table-driven directed vectors, hand-written backpressure and mid-operation
// reset sequences, then randomized operations compared against a reference
// model that clamps a*2^s using plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sat_arith_left_shift_seq;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_ovf;

  int checks = 0;
  int errors = 0;

  sat_arith_left_shift_seq #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     a;
    int     s;
    int     rdly;
    longint exp_data;
    longint exp_ovf;
    int     exp_lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the product a*2^k for k = 1..s. The first k that falls
  // outside the N-bit signed range is where overflow is detected.
  task automatic model(input int a, input int s, output longint d, output longint o, output int lat);
    longint lo, hi, p;
    lo = -(longint'(1) << (N - 1));
    hi = (longint'(1) << (N - 1)) - 1;
    p = a;
    o = 0;
    lat = s + 1;
    d = a;
    for (int k = 1; k <= s; k++) begin
      p = p * 2;
      if (p > hi || p < lo) begin
        o = 1;
        lat = k;
        d = (a < 0) ? lo : hi;
        break;
      end
      d = p;
    end
  endtask

  task automatic run_op(input int a, input int s, input int gap, input int rdly,
                        input longint ed, input longint eo, input int el, input string tag);
    int lat;
    int n;
    int bad;
    logic [N-1:0] held;
    repeat (gap) tick();
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " in_ready_before"}, longint'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = N'(a);
    in_shift = SW'(s);
    tick();
    in_valid = 1'b0;
    in_data  = N'($urandom);
    in_shift = SW'($urandom);
    chk({tag, " valid_after_accept"}, longint'(out_valid), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, longint'(lat), longint'(el));
    chk({tag, " data"}, longint'($signed(out_data)), ed);
    chk({tag, " ovf"}, longint'(out_ovf), eo);
    held = out_data;
    bad = 0;
    for (int i = 0; i < rdly; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = N'($urandom);
      in_shift = SW'($urandom);
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) bad++;
    end
    if (rdly > 0) chk({tag, " hold_errors"}, longint'(bad), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " ready_after_hs"}, longint'(in_ready), 1);
    chk({tag, " valid_after_hs"}, longint'(out_valid), 0);
  endtask

  vec_t vecs[13];

  initial begin
    longint md, mo;
    int ml;
    int a, s, bad;

    vecs[0]  = '{5,    3,  0, 40,   0, 4};
    vecs[1]  = '{-3,   4,  1, -48,  0, 5};
    vecs[2]  = '{20,   3,  0, 127,  1, 3};
    vecs[3]  = '{-65,  1,  2, -128, 1, 1};
    vecs[4]  = '{-128, 0,  0, -128, 0, 1};
    vecs[5]  = '{0,    15, 0, 0,    0, 16};
    vecs[6]  = '{1,    15, 0, 127,  1, 7};
    vecs[7]  = '{-128, 1,  0, -128, 1, 1};
    vecs[8]  = '{5,    2,  6, 20,   0, 3};
    vecs[9]  = '{64,   0,  0, 64,   0, 1};
    vecs[10] = '{127,  1,  0, 127,  1, 1};
    vecs[11] = '{-1,   7,  0, -128, 0, 8};
    vecs[12] = '{-1,   8,  0, -128, 1, 8};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("reset in_ready", longint'(in_ready), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset out_data", longint'(out_data), 0);
    chk("reset out_ovf", longint'(out_ovf), 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset in_ready", longint'(in_ready), 1);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].s, 1, vecs[i].rdly, vecs[i].exp_data,
             vecs[i].exp_ovf, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Reset while shifting: the in-flight result must vanish.
    in_valid = 1'b1;
    in_data  = 8'd1;
    in_shift = 4'd10;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready_low", longint'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready_high", longint'(in_ready), 1);
    chk("midrst out_data", longint'(out_data), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("midrst no_valid", longint'(bad), 0);
    run_op(3, 1, 0, 0, 6, 0, 2, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      a = int'($signed(N'($urandom)));
      s = int'($urandom_range(0, (1 << SW) - 1));
      model(a, s, md, mo, ml);
      run_op(a, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             md, mo, ml, $sformatf("rnd%0d a=%0d s=%0d", i, a, s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
